// File: rtl/alu_acc_pipe.sv
// Single-stage ALU with accumulator and valid/ready handshake on both sides.
// Define ALU_ACC_SAT_EN to saturate ADD/SUB results instead of wrapping.
module alu_acc_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [2:0]       io_fn,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    input  logic             io_use_acc,
    input  logic             io_acc_we,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_result,
    output logic [3:0]       io_flags,
    output logic [WIDTH-1:0] io_acc
);

    localparam int M = WIDTH - 1;

    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] acc_q;

    logic             xfer_in;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res_d;
    logic             carry;
    logic             ovf;
    logic [3:0]       flags_d;

    // Reset forces ready high so a stalled output cannot block the flush.
    assign io_in_ready = reset | ~out_valid_q | io_out_ready;
    assign xfer_in     = io_in_valid & io_in_ready;

    assign a_eff = io_use_acc ? acc_q : io_a;
    assign sum   = {1'b0, a_eff} + {1'b0, io_b};
    assign diff  = {1'b0, a_eff} - {1'b0, io_b};

    always_comb begin
        raw   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        unique case (io_fn)
            3'd0: begin
                raw   = sum[M:0];
                carry = sum[WIDTH];
                ovf   = (a_eff[M] == io_b[M]) && (sum[M] != a_eff[M]);
            end
            3'd1: begin
                raw   = diff[M:0];
                carry = diff[WIDTH];
                ovf   = (a_eff[M] != io_b[M]) && (diff[M] != a_eff[M]);
            end
            3'd2: raw = a_eff | io_b;
            3'd3: raw = a_eff & io_b;
            3'd4: raw = a_eff ^ io_b;
            3'd5: raw = a_eff << io_b[SHW-1:0];
            3'd6: raw = a_eff >> io_b[SHW-1:0];
            3'd7: raw = io_b;
        endcase
    end

`ifdef ALU_ACC_SAT_EN
    always_comb begin
        res_d = raw;
        if (io_fn == 3'd0 && carry)
            res_d = '1;
        else if (io_fn == 3'd1 && carry)
            res_d = '0;
    end
`else
    assign res_d = raw;
`endif

    assign flags_d = {ovf, carry, res_d[M], res_d == '0};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
        end else if (xfer_in) begin
            out_valid_q <= 1'b1;
            res_q       <= res_d;
            flags_q     <= flags_d;
            if (io_acc_we)
                acc_q <= res_d;
        end else if (io_out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign io_out_valid = out_valid_q;
    assign io_result    = res_q;
    assign io_flags     = flags_q;
    assign io_acc       = acc_q;

endmodule

// File: doc/alu_acc_pipe.md
ALU_ACC_PIPE -- requirements
Module: alu_acc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have parameter SHW, default 3, shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port io_in_valid, input, 1 bit: operation request present.
REQ-006 SHALL have port io_in_ready, output, 1 bit: block accepts the request this cycle.
REQ-007 SHALL have port io_fn, input, 3 bits: opcode.
REQ-008 SHALL have port io_a, input, WIDTH bits: operand A.
REQ-009 SHALL have port io_b, input, WIDTH bits: operand B.
REQ-010 SHALL have port io_use_acc, input, 1 bit: substitute the accumulator for operand A.
REQ-011 SHALL have port io_acc_we, input, 1 bit: write the result into the accumulator.
REQ-012 SHALL have port io_out_valid, output, 1 bit: result registered and valid.
REQ-013 SHALL have port io_out_ready, input, 1 bit: consumer takes the result.
REQ-014 SHALL have port io_result, output, WIDTH bits: registered result.
REQ-015 SHALL have port io_flags, output, 4 bits: {ovf, carry, neg, zero}, registered with io_result.
REQ-016 SHALL have port io_acc, output, WIDTH bits: current accumulator value.

Function
REQ-017 Transfer in = io_in_valid && io_in_ready; transfer out = io_out_valid && io_out_ready.
REQ-018 io_in_ready SHALL be !io_out_valid || io_out_ready, i.e. combinational pass-through of backpressure; no skid buffer.
REQ-019 Latency SHALL be exactly 1 cycle: an operation accepted in cycle N appears on io_result/io_flags with io_out_valid=1 in cycle N+1; full throughput of 1 op/cycle when io_out_ready=1.
REQ-020 While io_out_valid=1 && io_out_ready=0, io_result and io_flags SHALL hold stable; io_out_valid SHALL clear after transfer out when no transfer in occurs in the same cycle.
REQ-021 Effective A SHALL be io_acc when io_use_acc=1, else io_a.
REQ-022 Opcodes: 0 ADD A+B; 1 SUB A-B; 2 OR; 3 AND; 4 XOR; 5 SHL A<<B[SHW-1:0]; 6 SHR logical A>>B[SHW-1:0]; 7 PASS B.
REQ-023 Results SHALL be truncated to WIDTH bits (modulo 2^WIDTH) unless REQ-033 applies.
REQ-024 zero=1 iff result==0; neg=result[WIDTH-1].
REQ-025 carry SHALL be the ADD carry-out, or for SUB 1 iff A<B unsigned (borrow); carry=0 for all other opcodes.
REQ-026 ovf SHALL be signed two's-complement overflow for ADD/SUB, and 0 otherwise.
REQ-027 On a transfer in with io_acc_we=1, the accumulator SHALL be loaded with the (saturated, if enabled) result at the same edge that registers io_result.
REQ-028 Read-before-write: an op with io_use_acc=1 SHALL use the accumulator value from before its own write; back-to-back dependent ops SHALL see the previous op's write with no stall.
REQ-029 Inputs SHALL be ignored when no transfer in occurs; the accumulator SHALL change only per REQ-027.

Reset
REQ-030 With reset=1 at a clock edge: io_out_valid=0, io_result=0, io_flags=0, accumulator=0.
REQ-031 io_in_ready SHALL read 1 during and after reset; any request presented while reset=1 SHALL be discarded, including one already in flight (its result is lost).

Configuration
REQ-032 Macro ALU_ACC_SAT_EN SHALL select unsigned saturation for ADD/SUB.
REQ-033 If ALU_ACC_SAT_EN is defined: ADD with carry=1 yields all-ones; SUB with borrow yields 0; carry flag still reports the raw condition; ovf is unchanged.
REQ-034 If ALU_ACC_SAT_EN is undefined: ADD/SUB wrap per REQ-023; no saturation logic is instantiated.

Verification (WIDTH=8)
REQ-035 ADD a=0x7F, b=0x01, ready=1 -> next cycle result=0x80, flags ovf=1,neg=1,carry=0,zero=0.
REQ-036 SUB a=0x05, b=0x05 -> result=0x00, zero=1, carry=0; SUB a=0x03, b=0x05 -> result=0xFE, carry=1 (0x00 with ALU_ACC_SAT_EN).
REQ-037 ADD a=0xF0, b=0x20 -> result=0x10, carry=1 (0xFF with ALU_ACC_SAT_EN).
REQ-038 Accumulate: PASS b=0x03 acc_we=1, then three back-to-back ADD use_acc=1 acc_we=1 b=0x02 -> results 0x05, 0x07, 0x09; io_acc=0x09.
REQ-039 Backpressure: io_out_ready=0 for 4 cycles with a result pending -> io_in_ready=0 and result stable; the held op completes the cycle ready rises; no op is lost or duplicated.
REQ-040 Reset mid-stream with out_valid=1 and acc=0x09 -> next cycle out_valid=0, result=0, acc=0.
